decode_regfile: RTL and testbench
=================================

Name: decode_regfile

Overview:
- Decode stage of the Y86-64 pipeline. It sits directly downstream of the D pipeline register.
- It consumes D_icode/D_ifun/D_rA/D_rB/D_valC/D_valP/D_stat and produces d_srcA/d_srcB/d_dstE/d_dstM/d_valA/d_valB for the E register.
- It owns the 15-entry architectural register file, which is written from the W stage.
- It contains the full data-forwarding network from the e, M and W stages.

Parameters:
- DATA_W, 64, register and data width in bits.
- SP_INIT, 0, reset value of %rsp (register 4); all other registers reset to 0.

Ports:
- clk  in  1  pipeline clock; register file writes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- D_icode, D_ifun  in  4 each  instruction code/function from the D register.
- D_rA, D_rB  in  4 each  register specifiers; 4'hF = RNONE.
- D_valC, D_valP  in  DATA_W each  constant and incremented PC.
- D_stat  in  2  status from the D register (passed through).
- e_dstE  in  4, e_valE  in  DATA_W  execute-stage result (post-cmov dstE).
- M_dstE, M_dstM  in  4 each; M_valE  in  DATA_W; m_valM  in  DATA_W  memory-stage values.
- W_dstE, W_dstM  in  4 each; W_valE, W_valM  in  DATA_W  writeback values; also the write ports.
- d_srcA, d_srcB, d_dstE, d_dstM  out  4 each  decoded register IDs.
- d_valA, d_valB  out  DATA_W each  forwarded operand values.
- d_stat, d_icode, d_ifun  out  2/4/4  pass-through of D_stat/D_icode/D_ifun.
- d_valC  out  DATA_W  pass-through of D_valC.
- dbg_idx  in  4, dbg_val  out  DATA_W  combinational debug read of the register file; returns 0 for idx 15.

Behaviour:
- Reset: rst_n low asynchronously clears regs 0..14 to 0, except reg 4, which loads SP_INIT. Outputs are purely combinational from the inputs and the register file, so they settle to decode of the current inputs with the reset register contents.
- Register IDs (icodes: 0 halt, 1 nop, 2 rrmov/cmov, 3 irmov, 4 rmmov, 5 mrmov, 6 opq, 7 jxx, 8 call, 9 ret, A push, B pop):
  - d_srcA = D_rA for {2,4,6,A}; 4 (%rsp) for {9,B}; else F.
  - d_srcB = D_rB for {4,5,6}; 4 for {8,9,A,B}; else F.
  - d_dstE = D_rB for {2,3,6}; 4 for {8,9,A,B}; else F.
  - d_dstM = D_rA for {5,B}; else F.
  - Unknown icodes (C..F) decode all four IDs to F.
- d_valA priority, first match wins:
  1. icode in {7,8} -> D_valP.
  2. d_srcA==F -> 0.
  3. ==e_dstE -> e_valE.
  4. ==M_dstM -> m_valM.
  5. ==M_dstE -> M_valE.
  6. ==W_dstM -> W_valM.
  7. ==W_dstE -> W_valE.
  8. else register file read.
- d_valB: same chain starting at step 2, using d_srcB; no valP select.
- A forwarding match on ID F never occurs, because step 2 is checked first.
- Writes on posedge clk: W_dstE!=F writes W_valE; W_dstM!=F writes W_valM.
  - If W_dstE==W_dstM (e.g. popq %rsp), W_valM wins.
  - A write to F is ignored.
  - The register file read is the pre-edge value. Same-cycle W-stage values reach d_valA/d_valB through forwarding steps 6/7, not through write-through.
- Reset asserted mid-operation: registers clear immediately, and pending writes on that edge are discarded. Writes resume on the first rising edge with rst_n high.
- No stall or bubble inputs. The E register downstream handles those; this block holds no pipeline state except the register file.

Decomposition:
- Package y86_pkg holds:
  - icode constants (IHALT..IPOPQ).
  - RNONE=4'hF and RRSP=4'h4.
  - stat constants SAOK=0, SHLT=1, SADR=2, SINS=3.
- One sub-module: y86_regfile. It has 15 x DATA_W storage, two combinational read ports plus a debug port, two write ports with M-priority, and async active-low reset.
- Decode and forwarding logic stay in decode_regfile.

Test Plan:
- Reset/readback: pulse rst_n low with SP_INIT=64'h100 -> dbg_idx=4 gives 64'h100, dbg_idx=0..3 give 0; mid-cycle assert clears a just-written reg 3 to 0 with no clock edge.
- Write/read: W_dstE=2, W_valE=64'h55 for one edge, then W_dstE=F; D_icode=6, D_rA=2, D_rB=3 -> d_valA=64'h55, d_valB=0, d_dstE=3, d_dstM=F.
- Forwarding priority: D_icode=6, D_rA=1; drive e_dstE=1/e_valE=11, M_dstM=1/m_valM=22, M_dstE=1/M_valE=33, W_dstM=1/W_valM=44, W_dstE=1/W_valE=55 -> d_valA=11. Remove each source in turn -> 22, 33, 44, 55, then register value.
- valP select: D_icode=8 (call), D_valP=64'h2A, e_dstE=4 -> d_valA=64'h2A, d_srcB=4, d_dstE=4; D_icode=7 likewise gives d_valA=D_valP, d_srcA=F.
- Dual write conflict: W_dstE=4/W_valE=64'h10 and W_dstM=4/W_valM=64'h20 on the same edge -> dbg reg 4 = 64'h20. Separate regs 5/6 on one edge -> both written.
- Stack ops: D_icode=B (popq), D_rA=0 -> d_srcA=4, d_srcB=4, d_dstE=4, d_dstM=0; D_icode=D (invalid) -> all IDs F, d_valA=d_valB=0.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icode, register and status constants
package y86_pkg;
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] RRSP    = 4'h4;
    localparam logic [1:0] SAOK    = 2'd0;
    localparam logic [1:0] SHLT    = 2'd1;
    localparam logic [1:0] SADR    = 2'd2;
    localparam logic [1:0] SINS    = 2'd3;
endpackage

// File: rtl/y86_regfile.sv
// y86_regfile: 15-entry register file, two read ports, debug port, M-priority dual write
module y86_regfile
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter logic [DATA_W-1:0] SP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        rd_a,
    input  logic [3:0]        rd_b,
    input  logic [3:0]        dbg_idx,
    output logic [DATA_W-1:0] val_a,
    output logic [DATA_W-1:0] val_b,
    output logic [DATA_W-1:0] dbg_val,
    input  logic [3:0]        w_dst_e,
    input  logic [DATA_W-1:0] w_val_e,
    input  logic [3:0]        w_dst_m,
    input  logic [DATA_W-1:0] w_val_m
);
    logic [DATA_W-1:0] regs [0:14];

    // M write is issued last so it overrides E when both target the same register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++)
                regs[i] <= (i == 4) ? SP_INIT : '0;
        end else begin
            if (w_dst_e != RNONE) regs[w_dst_e] <= w_val_e;
            if (w_dst_m != RNONE) regs[w_dst_m] <= w_val_m;
        end
    end

    assign val_a   = (rd_a == RNONE) ? '0 : regs[rd_a];
    assign val_b   = (rd_b == RNONE) ? '0 : regs[rd_b];
    assign dbg_val = (dbg_idx == RNONE) ? '0 : regs[dbg_idx];
endmodule

// File: rtl/decode_regfile.sv
// decode_regfile: Y86-64 decode stage with register file and e/M/W forwarding
module decode_regfile
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter logic [DATA_W-1:0] SP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_ifun,
    input  logic [3:0]        D_rA,
    input  logic [3:0]        D_rB,
    input  logic [DATA_W-1:0] D_valC,
    input  logic [DATA_W-1:0] D_valP,
    input  logic [1:0]        D_stat,
    input  logic [3:0]        e_dstE,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [3:0]        W_dstE,
    input  logic [3:0]        W_dstM,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] W_valM,
    output logic [3:0]        d_srcA,
    output logic [3:0]        d_srcB,
    output logic [3:0]        d_dstE,
    output logic [3:0]        d_dstM,
    output logic [DATA_W-1:0] d_valA,
    output logic [DATA_W-1:0] d_valB,
    output logic [1:0]        d_stat,
    output logic [3:0]        d_icode,
    output logic [3:0]        d_ifun,
    output logic [DATA_W-1:0] d_valC,
    input  logic [3:0]        dbg_idx,
    output logic [DATA_W-1:0] dbg_val
);
    logic [DATA_W-1:0] rf_a, rf_b;

    y86_regfile #(.DATA_W(DATA_W), .SP_INIT(SP_INIT)) u_rf (
        .clk(clk), .rst_n(rst_n),
        .rd_a(d_srcA), .rd_b(d_srcB), .dbg_idx(dbg_idx),
        .val_a(rf_a), .val_b(rf_b), .dbg_val(dbg_val),
        .w_dst_e(W_dstE), .w_val_e(W_valE),
        .w_dst_m(W_dstM), .w_val_m(W_valM)
    );

    assign d_srcA = (D_icode inside {IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ}) ? D_rA :
                    (D_icode inside {IRET, IPOPQ}) ? RRSP : RNONE;
    assign d_srcB = (D_icode inside {IRMMOVQ, IMRMOVQ, IOPQ}) ? D_rB :
                    (D_icode inside {ICALL, IRET, IPUSHQ, IPOPQ}) ? RRSP : RNONE;
    assign d_dstE = (D_icode inside {IRRMOVQ, IIRMOVQ, IOPQ}) ? D_rB :
                    (D_icode inside {ICALL, IRET, IPUSHQ, IPOPQ}) ? RRSP : RNONE;
    assign d_dstM = (D_icode inside {IMRMOVQ, IPOPQ}) ? D_rA : RNONE;

    // youngest producer wins; the RNONE test precedes matching so idle stages never alias
    assign d_valA = (D_icode inside {IJXX, ICALL}) ? D_valP :
                    (d_srcA == RNONE)  ? '0     :
                    (d_srcA == e_dstE) ? e_valE :
                    (d_srcA == M_dstM) ? m_valM :
                    (d_srcA == M_dstE) ? M_valE :
                    (d_srcA == W_dstM) ? W_valM :
                    (d_srcA == W_dstE) ? W_valE : rf_a;
    assign d_valB = (d_srcB == RNONE)  ? '0     :
                    (d_srcB == e_dstE) ? e_valE :
                    (d_srcB == M_dstM) ? m_valM :
                    (d_srcB == M_dstE) ? M_valE :
                    (d_srcB == W_dstM) ? W_valM :
                    (d_srcB == W_dstE) ? W_valE : rf_b;

    assign d_stat  = D_stat;
    assign d_icode = D_icode;
    assign d_ifun  = D_ifun;
    assign d_valC  = D_valC;
endmodule

// File: tb/tb_decode_regfile.sv
// tb_decode_regfile: directed vectors for decode_regfile
module tb_decode_regfile;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [1:0]  D_stat;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
    logic [63:0] d_valA, d_valB, d_valC;
    logic [1:0]  d_stat;
    logic [3:0]  d_icode, d_ifun;
    logic [3:0]  dbg_idx;
    logic [63:0] dbg_val;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    decode_regfile #(.DATA_W(64), .SP_INIT(64'h100)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .d_valA(d_valA), .d_valB(d_valB),
        .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC),
        .dbg_idx(dbg_idx), .dbg_val(dbg_val)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] de, input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
        W_dstE = de; W_valE = ve; W_dstM = dm; W_valM = vm;
        tick();
        W_dstE = RNONE; W_dstM = RNONE;
        #1;
    endtask

    task automatic dbg(input string tag, input logic [3:0] idx, input logic [63:0] exp);
        dbg_idx = idx;
        #1;
        check(tag, dbg_val, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        D_icode = INOP; D_ifun = 4'h0; D_rA = RNONE; D_rB = RNONE;
        D_valC = 64'h0; D_valP = 64'h0; D_stat = SAOK;
        e_dstE = RNONE; M_dstE = RNONE; M_dstM = RNONE; W_dstE = RNONE; W_dstM = RNONE;
        e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
        dbg_idx = 4'h0;
        #22 rst_n = 1'b1;
        tick();
        dbg("rst_sp", 4'h4, 64'h100);
        for (int i = 0; i < 4; i++) dbg("rst_zero", 4'(i), 64'h0);
        dbg("dbg_none", 4'hF, 64'h0);

        wr(4'h2, 64'h55, RNONE, 64'h0);
        D_icode = IOPQ; D_rA = 4'h2; D_rB = 4'h3; D_ifun = 4'h1; D_valC = 64'hC0DE; D_stat = SADR;
        #1;
        check("wr_valA", d_valA, 64'h55);
        check("wr_valB", d_valB, 64'h0);
        check("op_srcA", d_srcA, 64'h2);
        check("op_srcB", d_srcB, 64'h3);
        check("op_dstE", d_dstE, 64'h3);
        check("op_dstM", d_dstM, 64'hF);
        check("pt_stat", d_stat, SADR);
        check("pt_ifun", d_ifun, 64'h1);
        check("pt_icode", d_icode, 64'h6);
        check("pt_valC", d_valC, 64'hC0DE);

        wr(4'h1, 64'h77, RNONE, 64'h0);
        D_rA = 4'h1;
        e_dstE = 4'h1; e_valE = 11; M_dstM = 4'h1; m_valM = 22; M_dstE = 4'h1; M_valE = 33;
        W_dstM = 4'h1; W_valM = 44; W_dstE = 4'h1; W_valE = 55;
        #1; check("fwd_e", d_valA, 64'd11);
        e_dstE = RNONE; #1; check("fwd_mM", d_valA, 64'd22);
        M_dstM = RNONE; #1; check("fwd_mE", d_valA, 64'd33);
        M_dstE = RNONE; #1; check("fwd_wM", d_valA, 64'd44);
        W_dstM = RNONE; #1; check("fwd_wE", d_valA, 64'd55);
        W_dstE = RNONE; #1; check("fwd_rf", d_valA, 64'h77);
        e_dstE = 4'h3; e_valE = 64'h99; #1; check("fwd_valB", d_valB, 64'h99);
        e_dstE = RNONE;

        D_icode = ICALL; D_valP = 64'h2A; e_dstE = 4'h4; e_valE = 64'hEE;
        #1;
        check("call_valA", d_valA, 64'h2A);
        check("call_srcB", d_srcB, 64'h4);
        check("call_dstE", d_dstE, 64'h4);
        check("call_valB", d_valB, 64'hEE);
        D_icode = IJXX; D_valP = 64'h3B;
        #1;
        check("jxx_valA", d_valA, 64'h3B);
        check("jxx_srcA", d_srcA, 64'hF);
        e_dstE = RNONE;

        wr(4'h4, 64'h10, 4'h4, 64'h20);
        dbg("dual_same", 4'h4, 64'h20);
        wr(4'h5, 64'hA5, 4'h6, 64'hB6);
        dbg("dual_r5", 4'h5, 64'hA5);
        dbg("dual_r6", 4'h6, 64'hB6);

        D_icode = IPOPQ; D_rA = 4'h0; D_rB = RNONE;
        #1;
        check("pop_srcA", d_srcA, 64'h4);
        check("pop_srcB", d_srcB, 64'h4);
        check("pop_dstE", d_dstE, 64'h4);
        check("pop_dstM", d_dstM, 64'h0);
        check("pop_valA", d_valA, 64'h20);
        D_icode = 4'hD; D_rA = 4'h1; D_rB = 4'h2;
        #1;
        check("inv_srcA", d_srcA, 64'hF);
        check("inv_srcB", d_srcB, 64'hF);
        check("inv_dstE", d_dstE, 64'hF);
        check("inv_dstM", d_dstM, 64'hF);
        check("inv_valA", d_valA, 64'h0);
        check("inv_valB", d_valB, 64'h0);

        wr(4'h3, 64'h33, RNONE, 64'h0);
        dbg("pre_rst_r3", 4'h3, 64'h33);
        #1 rst_n = 1'b0;
        dbg("mid_rst_r3", 4'h3, 64'h0);
        dbg("mid_rst_sp", 4'h4, 64'h100);
        W_dstE = 4'h3; W_valE = 64'hDEAD;
        tick();
        dbg("rst_hold_r3", 4'h3, 64'h0);
        rst_n = 1'b1;
        tick();
        W_dstE = RNONE;
        dbg("resume_r3", 4'h3, 64'hDEAD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
